// File: rtl/hazard_stall_ctrl_if.sv
// Signal bundle between the hazard/stall controller and the pipeline datapath.
// The pipeline side (master) supplies hazard inputs; the controller (slave) returns enables and status.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       RS1addr_IF_ID_i;
  logic [4:0]       RS2addr_IF_ID_i;
  logic             RS2used_i;
  logic [4:0]       RDaddr_ID_EX_i;
  logic             MemRead_ID_EX_i;
  logic             Branch_taken_i;
  logic             mem_stall_i;
  logic             PCWrite_o;
  logic             IF_ID_Write_o;
  logic             NoOp_o;
  logic             Flush_o;
  logic             Freeze_o;
  logic             timeout_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output RS1addr_IF_ID_i, RS2addr_IF_ID_i, RS2used_i, RDaddr_ID_EX_i,
           MemRead_ID_EX_i, Branch_taken_i, mem_stall_i,
    input  PCWrite_o, IF_ID_Write_o, NoOp_o, Flush_o, Freeze_o,
           timeout_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  RS1addr_IF_ID_i, RS2addr_IF_ID_i, RS2used_i, RDaddr_ID_EX_i,
           MemRead_ID_EX_i, Branch_taken_i, mem_stall_i,
    output PCWrite_o, IF_ID_Write_o, NoOp_o, Flush_o, Freeze_o,
           timeout_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage core: load-use bubbles, taken-branch flushes,
// data-memory wait freezes, a wait-timeout watchdog and saturating stall/flush counters.
module hazard_stall_ctrl #(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  hazard_stall_ctrl_if.slave hz
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {RUN, LU_BUBBLE, MEM_WAIT} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              timeout;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  logic mem_stall;
  logic load_use;
  logic branch;
  logic pc_write;
  logic if_id_write;
  logic noop;
  logic flush;
  logic freeze;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    sat_inc = (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  // Inputs are gated while reset is held so the outputs show plain RUN values.
  always_comb begin
    mem_stall = hz.mem_stall_i & ~rst_i;
    branch    = hz.Branch_taken_i & ~rst_i;
    load_use  = ~rst_i && (state != LU_BUBBLE) && hz.MemRead_ID_EX_i &&
                (hz.RDaddr_ID_EX_i != 5'd0) &&
                ((hz.RDaddr_ID_EX_i == hz.RS1addr_IF_ID_i) ||
                 (hz.RS2used_i && (hz.RDaddr_ID_EX_i == hz.RS2addr_IF_ID_i)));
  end

  // A MEM_WAIT cycle with the memory ready behaves exactly like RUN, so one decode serves all states.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    noop        = 1'b0;
    flush       = 1'b0;
    freeze      = 1'b0;
    state_nxt   = RUN;
    wait_nxt    = '0;
    if (mem_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      freeze      = 1'b1;
      state_nxt   = MEM_WAIT;
      if (state != MEM_WAIT)
        wait_nxt = WAIT_W'(1);
      else if (wait_cnt == WAIT_W'(MAX_WAIT))
        wait_nxt = wait_cnt;
      else
        wait_nxt = wait_cnt + WAIT_W'(1);
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      noop        = 1'b1;
      state_nxt   = LU_BUBBLE;
    end else if (branch) begin
      flush = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      stall_cnt <= sat_inc(stall_cnt, ~pc_write);
      flush_cnt <= sat_inc(flush_cnt, flush);
      // Sticky: only reset clears it; the freeze itself continues regardless.
      if (mem_stall && (wait_nxt == WAIT_W'(MAX_WAIT)))
        timeout <= 1'b1;
    end
  end

  assign hz.PCWrite_o     = pc_write;
  assign hz.IF_ID_Write_o = if_id_write;
  assign hz.NoOp_o        = noop;
  assign hz.Flush_o       = flush;
  assign hz.Freeze_o      = freeze;
  assign hz.timeout_o     = timeout;
  assign hz.stall_cnt_o   = stall_cnt;
  assign hz.flush_cnt_o   = flush_cnt;

endmodule
